oled_seq_arbiter: RTL and testbench
===================================

// Module: oled_seq_arbiter
// PURPOSE
//  Top-level scheduler for the OLED path. After reset it sequences the panel
//  through init, then full-screen clear, then repeated frame writes.
//  It time-shares the single SPI byte sender among three clients: oled_init,
//  oled_clear and the frame writer. Clients keep their native send/data/dc/done
//  handshake; this block grants exactly one client at a time.
// PARAMETERS
//  FRAME_GAP  16       idle cycles enforced after each frame before the next start
//  WDOG_CYC   1048576  cycles with no spi_done while a client runs -> error
//  WDOG_W     21       width of the watchdog counter (>= clog2(WDOG_CYC)+1)
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high reset
//  spi_done        in   1  1-cycle pulse from SPI sender: byte finished
//  spi_send        out  1  byte request to SPI sender (level, held until spi_done)
//  spi_data        out  8  byte to send
//  spi_dc          out  1  0=command, 1=data
//  init_start      out  1  1-cycle start pulse to init client
//  init_send       in   1  init client byte request
//  init_data       in   8  init client byte
//  init_dc         in   1  init client D/C
//  init_send_done  out  1  spi_done routed to init client
//  init_done       in   1  init client finished (>=1-cycle pulse)
//  clear_start/clear_send/clear_data/clear_dc/clear_send_done/clear_done
//                      same set for the clear client
//  frame_start/frame_send/frame_data/frame_dc/frame_send_done/frame_done
//                      same set for the frame client
//  frame_req       in   1  pulse: new frame available
//  clear_req       in   1  pulse: request a full-screen clear
//  ready           out  1  init+clear completed, controller in READY
//  busy            out  1  a client currently holds the grant
//  error           out  1  sticky watchdog error
//  drop_cnt        out  8  saturating count of frame_req lost while one pending
// BEHAVIOUR
//  Reset: on the clk edge with reset=1, state<=IDLE, and every output, the
//   pending flags, gap counter and watchdog all go to 0. Reset mid-transfer
//   aborts it; the granted client sees no send_done.
//  FSM (one transition per clk):
//   IDLE -> INIT_ST (auto, next cycle)
//   INIT_ST (init_start=1) -> INIT_RUN
//   INIT_RUN: on init_done -> CLR_ST
//   CLR_ST (clear_start=1) -> CLR_RUN
//   CLR_RUN: on clear_done -> READY
//   READY: clear_pend -> CLR_ST; else frame_pend -> FRM_ST (clear has priority)
//   FRM_ST (frame_start=1) -> FRM_RUN
//   FRM_RUN: on frame_done -> GAP
//   GAP: count FRAME_GAP cycles -> READY
//   any *_RUN with watchdog==WDOG_CYC -> ERR
//   ERR: terminal until reset
//  Grant: owner = client of current *_ST/*_RUN state.
//   spi_send = owner_send in *_RUN only, 0 elsewhere.
//   spi_data/spi_dc = owner's values in *_RUN, 0 elsewhere.
//   Combinational path, 0-cycle latency.
//   <client>_send_done = spi_done & (owner==client) & in RUN; other clients get 0.
//   Non-owner send requests are ignored, not queued.
//  *_done coinciding with spi_done: both honored; send_done delivered this
//   cycle, state advances next edge.
//  Pending flags:
//   frame_req sets frame_pend in any state except ERR; FRM_ST clears it.
//   frame_req while frame_pend=1 (and not cleared the same cycle): drop_cnt+1,
//   saturating at 255.
//   clear_req sets clear_pend; CLR_ST clears it. Requests made during IDLE..CLR_RUN
//   are retained. Set and clear in the same cycle: set wins.
//  Watchdog: zeroed on every state change and every spi_done; increments in
//   *_RUN. WDOG_W wide, no wrap.
//  Outputs: ready=(state==READY); busy=(state in *_ST/*_RUN); error=(state==ERR);
//   start pulses last exactly 1 cycle.
// STRUCTURE
//  oled_defs.vh: state encodings, client IDs (CL_NONE/CL_INIT/CL_CLEAR/CL_FRAME)
//   as localparams.
//  Sub-module oled_spi_mux: combinational 3:1 mux of send/data/dc plus
//   send_done demux, selected by client ID. FSM, counters and flags stay here.
// TESTING
//  T1: reset 4 cyc, init model sends 3 bytes then done -> init_start at cyc 1,
//   3 spi_send/spi_done pairs, clear_start 1 cyc after init_done.
//  T2: clear model sends 1 byte/dc=1, then done -> ready=1 the cycle after
//   clear_done; frame_req pulse -> frame_start after 1 cyc, GAP lasts 16 cyc.
//  T3: during FRM_RUN, init_send=1 and clear_send=1 held -> spi_data stays
//   frame_data; init/clear_send_done stay 0.
//  T4: 3 frame_req during FRM_RUN -> drop_cnt=2, exactly one further frame;
//   clear_req+frame_req together in READY -> CLR_ST first.
//  T5: frame model never returns spi_done (WDOG_CYC=64) -> error=1 on the 65th
//   RUN cycle, spi_send=0, sticky; reset -> IDLE, all outputs 0.
//  T6: reset asserted mid-byte in CLR_RUN -> next edge all outputs 0, init
//   sequence restarts.

Source files
------------

// File: rtl/oled_seq_arbiter_pkg.sv
// Shared types for the OLED scheduler: controller states, SPI client IDs and
// small state-classification helpers used by the top and the SPI mux.
package oled_seq_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT_ST  = 4'd1,
    ST_INIT_RUN = 4'd2,
    ST_CLR_ST   = 4'd3,
    ST_CLR_RUN  = 4'd4,
    ST_READY    = 4'd5,
    ST_FRM_ST   = 4'd6,
    ST_FRM_RUN  = 4'd7,
    ST_GAP      = 4'd8,
    ST_ERR      = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    CL_NONE  = 2'd0,
    CL_INIT  = 2'd1,
    CL_CLEAR = 2'd2,
    CL_FRAME = 2'd3
  } client_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Owner of the SPI sender: the client whose start or run state is active.
  function automatic client_t state_owner(input state_t s);
    client_t c;
    case (s)
      ST_INIT_ST, ST_INIT_RUN: c = CL_INIT;
      ST_CLR_ST,  ST_CLR_RUN:  c = CL_CLEAR;
      ST_FRM_ST,  ST_FRM_RUN:  c = CL_FRAME;
      default:                 c = CL_NONE;
    endcase
    return c;
  endfunction

  function automatic logic is_run(input state_t s);
    return (s == ST_INIT_RUN) || (s == ST_CLR_RUN) || (s == ST_FRM_RUN);
  endfunction

  function automatic logic is_start(input state_t s);
    return (s == ST_INIT_ST) || (s == ST_CLR_ST) || (s == ST_FRM_ST);
  endfunction

endpackage

// File: rtl/oled_seq_arbiter_spi_mux.sv
// Combinational 3:1 mux of client send/data/dc onto the single SPI sender,
// plus the matching demux of spi_done back to the selected client.
module oled_seq_arbiter_spi_mux
  import oled_seq_arbiter_pkg::*;
(
  input  client_t    sel,
  input  logic       run,
  input  logic       init_send,
  input  logic [7:0] init_data,
  input  logic       init_dc,
  input  logic       clear_send,
  input  logic [7:0] clear_data,
  input  logic       clear_dc,
  input  logic       frame_send,
  input  logic [7:0] frame_data,
  input  logic       frame_dc,
  input  logic       spi_done,
  output logic       spi_send,
  output logic [7:0] spi_data,
  output logic       spi_dc,
  output logic       init_send_done,
  output logic       clear_send_done,
  output logic       frame_send_done
);

  // Handshake: a granted client holds send with stable data/dc until the
  // sender returns a 1-cycle spi_done; that pulse reaches only the owner.
  // Outside a run state nothing is forwarded, so stray requests are dropped.
  always_comb begin
    spi_send        = 1'b0;
    spi_data        = 8'h00;
    spi_dc          = 1'b0;
    init_send_done  = 1'b0;
    clear_send_done = 1'b0;
    frame_send_done = 1'b0;
    if (run) begin
      case (sel)
        CL_INIT: begin
          spi_send       = init_send;
          spi_data       = init_data;
          spi_dc         = init_dc;
          init_send_done = spi_done;
        end
        CL_CLEAR: begin
          spi_send        = clear_send;
          spi_data        = clear_data;
          spi_dc          = clear_dc;
          clear_send_done = spi_done;
        end
        CL_FRAME: begin
          spi_send        = frame_send;
          spi_data        = frame_data;
          spi_dc          = frame_dc;
          frame_send_done = spi_done;
        end
        default: begin
          spi_send = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/oled_seq_arbiter.sv
// OLED path scheduler: sequences init, clear and repeated frame writes and
// grants the single SPI byte sender to exactly one client at a time.
module oled_seq_arbiter
  import oled_seq_arbiter_pkg::*;
#(
  parameter int unsigned FRAME_GAP = 16,
  parameter int unsigned WDOG_CYC  = 1048576,
  parameter int unsigned WDOG_W    = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_done,
  output logic       spi_send,
  output logic [7:0] spi_data,
  output logic       spi_dc,
  output logic       init_start,
  input  logic       init_send,
  input  logic [7:0] init_data,
  input  logic       init_dc,
  output logic       init_send_done,
  input  logic       init_done,
  output logic       clear_start,
  input  logic       clear_send,
  input  logic [7:0] clear_data,
  input  logic       clear_dc,
  output logic       clear_send_done,
  input  logic       clear_done,
  output logic       frame_start,
  input  logic       frame_send,
  input  logic [7:0] frame_data,
  input  logic       frame_dc,
  output logic       frame_send_done,
  input  logic       frame_done,
  input  logic       frame_req,
  input  logic       clear_req,
  output logic       ready,
  output logic       busy,
  output logic       error,
  output logic [7:0] drop_cnt,
  output state_t     state_dbg
);

  localparam int unsigned GAP_W = $clog2(FRAME_GAP) + 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(FRAME_GAP - 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYC);

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              frame_pend_q, clear_pend_q;
  logic [7:0]        drop_q;
  logic              frame_set, frame_clr, clear_set, clear_clr, drop_inc;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_INIT_ST;
      ST_INIT_ST:  state_d = ST_INIT_RUN;
      ST_INIT_RUN: if (init_done) state_d = ST_CLR_ST;
      ST_CLR_ST:   state_d = ST_CLR_RUN;
      ST_CLR_RUN:  if (clear_done) state_d = ST_READY;
      ST_READY: begin
        if (clear_pend_q)      state_d = ST_CLR_ST;
        else if (frame_pend_q) state_d = ST_FRM_ST;
      end
      ST_FRM_ST:   state_d = ST_FRM_RUN;
      ST_FRM_RUN:  if (frame_done) state_d = ST_GAP;
      ST_GAP:      if (gap_q == GAP_LAST) state_d = ST_READY;
      ST_ERR:      state_d = ST_ERR;
      default:     state_d = ST_IDLE;
    endcase
    // A stalled client outranks its own done: the run is declared dead.
    if (is_run(state_q) && (wdog_q == WDOG_LIM)) state_d = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= '0;
    end else if ((state_q == ST_GAP) && (state_d == ST_GAP)) begin
      gap_q <= gap_q + 1'b1;
    end else begin
      gap_q <= '0;
    end
  end

  // Watchdog measures time since the last sender progress inside a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else if ((state_d != state_q) || spi_done) begin
      wdog_q <= '0;
    end else if (is_run(state_q) && (wdog_q != WDOG_LIM)) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  // Requests are ignored once in ERR; a set beats a same-cycle consume.
  assign frame_set = frame_req && (state_q != ST_ERR);
  assign frame_clr = (state_q == ST_FRM_ST);
  assign clear_set = clear_req && (state_q != ST_ERR);
  assign clear_clr = (state_q == ST_CLR_ST);
  assign drop_inc  = frame_set && frame_pend_q && !frame_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_pend_q <= 1'b0;
      clear_pend_q <= 1'b0;
      drop_q       <= 8'h00;
    end else begin
      if (frame_set)      frame_pend_q <= 1'b1;
      else if (frame_clr) frame_pend_q <= 1'b0;
      if (clear_set)      clear_pend_q <= 1'b1;
      else if (clear_clr) clear_pend_q <= 1'b0;
      if (drop_inc && (drop_q != DROP_MAX)) drop_q <= drop_q + 8'd1;
    end
  end

  oled_seq_arbiter_spi_mux u_spi_mux (
    .sel             (state_owner(state_q)),
    .run             (is_run(state_q)),
    .init_send       (init_send),
    .init_data       (init_data),
    .init_dc         (init_dc),
    .clear_send      (clear_send),
    .clear_data      (clear_data),
    .clear_dc        (clear_dc),
    .frame_send      (frame_send),
    .frame_data      (frame_data),
    .frame_dc        (frame_dc),
    .spi_done        (spi_done),
    .spi_send        (spi_send),
    .spi_data        (spi_data),
    .spi_dc          (spi_dc),
    .init_send_done  (init_send_done),
    .clear_send_done (clear_send_done),
    .frame_send_done (frame_send_done)
  );

  assign init_start  = (state_q == ST_INIT_ST);
  assign clear_start = (state_q == ST_CLR_ST);
  assign frame_start = (state_q == ST_FRM_ST);
  assign ready       = (state_q == ST_READY);
  assign busy        = is_start(state_q) || is_run(state_q);
  assign error       = (state_q == ST_ERR);
  assign drop_cnt    = drop_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_oled_seq_arbiter.sv
// Directed-plus-random bench for oled_seq_arbiter: byte-level scoreboard of
// the SPI stream, sequencing timing, arbitration, drops, watchdog and reset.
module tb_oled_seq_arbiter;
  import oled_seq_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_done;
  logic       spi_send;
  logic [7:0] spi_data;
  logic       spi_dc;
  logic       init_start, init_send, init_dc, init_send_done, init_done;
  logic [7:0] init_data;
  logic       clear_start, clear_send, clear_dc, clear_send_done, clear_done;
  logic [7:0] clear_data;
  logic       frame_start, frame_send, frame_dc, frame_send_done, frame_done;
  logic [7:0] frame_data;
  logic       frame_req, clear_req;
  logic       ready, busy, error;
  logic [7:0] drop_cnt;
  logic [3:0] state_dbg;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int drop_exp = 0;

  oled_seq_arbiter #(.FRAME_GAP(16), .WDOG_CYC(64), .WDOG_W(8)) dut (
    .clk(clk), .reset(reset), .spi_done(spi_done),
    .spi_send(spi_send), .spi_data(spi_data), .spi_dc(spi_dc),
    .init_start(init_start), .init_send(init_send), .init_data(init_data),
    .init_dc(init_dc), .init_send_done(init_send_done), .init_done(init_done),
    .clear_start(clear_start), .clear_send(clear_send), .clear_data(clear_data),
    .clear_dc(clear_dc), .clear_send_done(clear_send_done), .clear_done(clear_done),
    .frame_start(frame_start), .frame_send(frame_send), .frame_data(frame_data),
    .frame_dc(frame_dc), .frame_send_done(frame_send_done), .frame_done(frame_done),
    .frame_req(frame_req), .clear_req(clear_req),
    .ready(ready), .busy(busy), .error(error), .drop_cnt(drop_cnt),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {5'd0, spi_send, spi_data, spi_dc, init_start, clear_start, frame_start,
                init_send_done, clear_send_done, frame_send_done,
                ready, busy, error, drop_cnt}, 32'd0);
  endtask

  // Drivers
  task automatic set_client(input int cl, input logic s, input logic [7:0] d, input logic c);
    case (cl)
      1: begin init_send = s;  init_data = d;  init_dc = c;  end
      2: begin clear_send = s; clear_data = d; clear_dc = c; end
      default: begin frame_send = s; frame_data = d; frame_dc = c; end
    endcase
  endtask

  // One byte from client cl; the bench plays the SPI sender with random latency.
  task automatic send_byte(input int cl, input logic dc, input string tag);
    logic [7:0] d;
    logic [8:0] e;
    logic [2:0] done_exp;
    int lat;
    d = 8'($urandom);
    exp_q.push_back({dc, d});
    set_client(cl, 1'b1, d, dc);
    #1;
    check({tag, " spi_send"}, {31'd0, spi_send}, 32'd1);
    e = exp_q.pop_front();
    check({tag, " dc+data"}, {23'd0, spi_dc, spi_data}, {23'd0, e});
    lat = $urandom_range(0, 3);
    for (int i = 0; i < lat; i++) step();
    spi_done = 1'b1;
    #1;
    done_exp = (cl == 1) ? 3'b100 : (cl == 2) ? 3'b010 : 3'b001;
    check({tag, " send_done"}, {29'd0, init_send_done, clear_send_done, frame_send_done},
          {29'd0, done_exp});
    step();
    spi_done = 1'b0;
    set_client(cl, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic expect_init_start(input string tag);
    check({tag, " idle"}, {30'd0, init_start, busy}, 32'd0);
    step();
    check({tag, " init_start"}, {30'd0, init_start, busy}, 32'd3);
    step();
    check({tag, " init_start 1cyc"}, {31'd0, init_start}, 32'd0);
  endtask

  task automatic measure_gap(input string tag);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      n++;
      step();
    end
    check({tag, " gap length"}, n, 32'd16);
  endtask

  initial begin
    int nreq, n, extra;
    reset = 1'b1; spi_done = 1'b0; frame_req = 1'b0; clear_req = 1'b0;
    init_done = 1'b0; clear_done = 1'b0; frame_done = 1'b0;
    set_client(1, 1'b0, 8'h00, 1'b0);
    set_client(2, 1'b0, 8'h00, 1'b0);
    set_client(3, 1'b0, 8'h00, 1'b0);

    // T1: reset, init with 3 bytes, clear starts right after init_done
    repeat (4) step();
    check_all_zero("reset outputs");
    check("reset state", {28'd0, state_dbg}, {28'd0, ST_IDLE});
    reset = 1'b0;
    expect_init_start("t1");
    for (int i = 0; i < 3; i++) send_byte(1, 1'($urandom), "t1 init byte");
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    check("t1 clear_start", {30'd0, clear_start, init_start}, 32'd2);
    step();
    check("t1 clear_start 1cyc", {31'd0, clear_start}, 32'd0);

    // T2: clear one data byte, ready, frame request, frame start
    send_byte(2, 1'b1, "t2 clear byte");
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    check("t2 ready", {29'd0, ready, busy, error}, 32'd4);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    check("t2 req seen", {30'd0, ready, frame_start}, 32'd2);
    step();
    check("t2 frame_start", {30'd0, ready, frame_start}, 32'd1);
    step();

    // T3/T4: rival clients held, extra frame requests during the run
    init_send = 1'b1; init_data = 8'hA5;
    clear_send = 1'b1; clear_data = 8'h5A;
    send_byte(3, 1'($urandom), "t3 frame byte");
    nreq = $urandom_range(2, 5);
    for (int i = 0; i < nreq; i++) begin
      frame_req = 1'b1;
      step();
      frame_req = 1'b0;
      step();
    end
    drop_exp += nreq - 1;
    send_byte(3, 1'($urandom), "t3 frame byte2");
    init_send = 1'b0; clear_send = 1'b0;
    check("t4 drop_cnt", {24'd0, drop_cnt}, drop_exp);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    measure_gap("t2");
    step();
    check("t4 second frame", {31'd0, frame_start}, 32'd1);
    step();
    send_byte(3, 1'($urandom), "t4 frame byte");
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    measure_gap("t4");
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (frame_start || busy || !ready) extra++;
      step();
    end
    check("t4 no extra frame", extra, 32'd0);

    clear_req = 1'b1; frame_req = 1'b1;
    step();
    clear_req = 1'b0; frame_req = 1'b0;
    check("t4 both pend ready", {31'd0, ready}, 32'd1);
    step();
    check("t4 clear first", {30'd0, clear_start, frame_start}, 32'd2);
    step();
    send_byte(2, 1'($urandom), "t4 clear byte");
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    check("t4 ready after clear", {31'd0, ready}, 32'd1);
    step();
    check("t4 frame after clear", {31'd0, frame_start}, 32'd1);
    check("t4 drop unchanged", {24'd0, drop_cnt}, drop_exp);
    step();

    // T5: stalled frame byte trips the watchdog
    frame_send = 1'b1; frame_data = 8'h3C;
    #1;
    n = 0;
    while (!error && n < 200) begin
      if (spi_send) n++;
      step();
    end
    check("t5 run cycles before error", n, 32'd65);
    check("t5 err outputs", {28'd0, error, spi_send, busy, ready}, 32'd8);
    check("t5 err state", {28'd0, state_dbg}, {28'd0, ST_ERR});
    for (int i = 0; i < 2; i++) begin
      frame_req = 1'b1;
      step();
      frame_req = 1'b0;
      step();
    end
    repeat (10) step();
    check("t5 sticky", {31'd0, error}, 32'd1);
    check("t5 no drop in err", {24'd0, drop_cnt}, drop_exp);
    reset = 1'b1;
    frame_send = 1'b0;
    step();
    drop_exp = 0;
    check_all_zero("t5 reset");
    reset = 1'b0;
    expect_init_start("t5");

    // T6: reset mid-byte in the clear run
    send_byte(1, 1'($urandom), "t6 init byte");
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    step();
    clear_send = 1'b1; clear_data = 8'hC3; clear_dc = 1'b1;
    #1;
    check("t6 clear mid-byte", {23'd0, spi_send, spi_data}, {23'd0, 1'b1, 8'hC3});
    reset = 1'b1;
    step();
    spi_done = 1'b1;
    #1;
    check_all_zero("t6 reset");
    spi_done = 1'b0;
    clear_send = 1'b0;
    reset = 1'b0;
    expect_init_start("t6");

    check("scoreboard empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
